// File: rtl/tr_track_ctrl_if.sv
// ADC capture bundle for the tracking regulator:
// one-cycle sample strobe plus sample data.
interface tr_track_ctrl_if #(
    parameter int DW = 12
);
    logic          data_valid;
    logic [DW-1:0] x;

    modport master (
        output data_valid,
        output x
    );

    modport slave (
        input data_valid,
        input x
    );
endinterface

// File: rtl/tr_track_ctrl.sv
// Tracking regulator: averages ADC samples against setpoint x0 and
// steps the drive back into the deadband at a slow or fast rate.
module tr_track_ctrl #(
    parameter int DW        = 12,
    parameter int AVG_LOG2  = 2,
    parameter int SLOW_DIV  = 1000,
    parameter int FAST_DIV  = 250,
    parameter int PULSE_W   = 1,
    parameter int MAX_STEPS = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           tr_mode_enable,
    tr_track_ctrl_if.slave adc,
    input  logic [DW-1:0]  x0,
    input  logic [DW-1:0]  dx1,
    input  logic [DW-1:0]  dx2,
    output logic           drv_SM,
    output logic           drv_step,
    output logic           drv_dir,
    output logic           locked,
    output logic           fault,
    output logic [DW-1:0]  avg
);

    localparam int AW  = DW + AVG_LOG2;
    localparam int SCW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int MDV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int PW  = $clog2(MDV);
    localparam int KW  = $clog2(MAX_STEPS + 1);

    localparam logic [SCW-1:0] SLAST = SCW'((1 << AVG_LOG2) - 1);
    localparam logic [PW-1:0]  PLIM  = PW'(PULSE_W);
    localparam logic [PW-1:0]  SLAST_P = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0]  FLAST_P = PW'(FAST_DIV - 1);
    localparam logic [KW-1:0]  KMAX  = KW'(MAX_STEPS);

    typedef enum logic [2:0] {
        IDLE, ACQ, HOLD, SLOW, FAST, FAULT
    } state_t;

    state_t         state;
    state_t         zone;
    state_t         pend_z;
    state_t         eff_z;
    logic [AW-1:0]  acc;
    logic [AW-1:0]  sum;
    logic [SCW-1:0] scnt;
    logic           avg_ok;
    logic [DW:0]    e;
    logic [DW-1:0]  mag;
    logic           dir_now;
    logic [PW-1:0]  pcnt;
    logic [PW-1:0]  plast;
    logic           bnd;
    logic [KW-1:0]  kcnt;
    logic           pend_v;
    logic           pend_d;
    logic           eff_v;
    logic           eff_d;

    assign sum = acc + AW'(adc.x);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc    <= '0;
            scnt   <= '0;
            avg    <= '0;
            avg_ok <= 1'b0;
        end else begin
            avg_ok <= 1'b0;
            if (!tr_mode_enable) begin
                acc  <= '0;
                scnt <= '0;
            end else if (adc.data_valid) begin
                if (scnt == SLAST) begin
                    avg    <= sum[AW-1:AVG_LOG2];
                    acc    <= '0;
                    scnt   <= '0;
                    avg_ok <= 1'b1;
                end else begin
                    acc  <= sum;
                    scnt <= scnt + 1'b1;
                end
            end
        end
    end

    assign e       = {1'b0, avg} - {1'b0, x0};
    assign mag     = e[DW] ? (~e[DW-1:0] + 1'b1) : e[DW-1:0];
    assign dir_now = avg > x0;

    always_comb begin
        zone = SLOW;
        if (mag <= dx1) begin
            zone = HOLD;
        end else if (mag > dx2) begin
            zone = FAST;
        end
    end

    // A decision arriving on the boundary cycle itself applies at once.
    assign eff_v = avg_ok | pend_v;
    assign eff_z = avg_ok ? zone : pend_z;
    assign eff_d = avg_ok ? dir_now : pend_d;

    assign plast = (state == FAST) ? FLAST_P : SLAST_P;
    assign bnd   = pcnt == plast;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pcnt     <= '0;
            kcnt     <= '0;
            pend_v   <= 1'b0;
            pend_z   <= HOLD;
            pend_d   <= 1'b0;
            drv_SM   <= 1'b0;
            drv_step <= 1'b0;
            drv_dir  <= 1'b0;
            locked   <= 1'b0;
            fault    <= 1'b0;
        end else if (!tr_mode_enable) begin
            state    <= IDLE;
            pcnt     <= '0;
            kcnt     <= '0;
            pend_v   <= 1'b0;
            drv_SM   <= 1'b0;
            drv_step <= 1'b0;
            locked   <= 1'b0;
            fault    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state  <= ACQ;
                    drv_SM <= 1'b1;
                end
                ACQ, HOLD: begin
                    kcnt <= '0;
                    if (avg_ok) begin
                        state   <= zone;
                        drv_dir <= dir_now;
                        locked  <= zone == HOLD;
                        pcnt    <= '0;
                    end
                end
                SLOW, FAST: begin
                    if (avg_ok) begin
                        pend_v <= 1'b1;
                        pend_z <= zone;
                        pend_d <= dir_now;
                    end
                    // Step is already low here, so a new dir gets 1 clk setup.
                    if (bnd) begin
                        pcnt     <= '0;
                        drv_step <= 1'b0;
                        if (kcnt == KMAX) begin
                            state  <= FAULT;
                            drv_SM <= 1'b0;
                            fault  <= 1'b1;
                            pend_v <= 1'b0;
                        end else if (eff_v) begin
                            state   <= eff_z;
                            drv_dir <= eff_d;
                            locked  <= eff_z == HOLD;
                            pend_v  <= 1'b0;
                        end
                    end else begin
                        pcnt     <= pcnt + 1'b1;
                        drv_step <= pcnt < PLIM;
                        if (pcnt == '0) begin
                            kcnt <= kcnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tr_track_ctrl.sv
// Bench for tr_track_ctrl: phase-arithmetic reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_tr_track_ctrl;

    localparam int DIV_S = 8;
    localparam int DIV_F = 4;
    localparam int PWID  = 1;
    localparam int MAXS  = 6;
    localparam int NAVG  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [11:0] x0;
    logic [11:0] dx1;
    logic [11:0] dx2;
    logic        drv_SM;
    logic        drv_step;
    logic        drv_dir;
    logic        locked;
    logic        fault;
    logic [11:0] avg;

    int total = 0;
    int bad   = 0;

    tr_track_ctrl_if #(.DW(12)) adc ();

    tr_track_ctrl #(
        .DW(12), .AVG_LOG2(2), .SLOW_DIV(DIV_S), .FAST_DIV(DIV_F),
        .PULSE_W(PWID), .MAX_STEPS(MAXS)
    ) dut (
        .clk(clk), .rst(rst), .tr_mode_enable(en), .adc(adc),
        .x0(x0), .dx1(dx1), .dx2(dx2),
        .drv_SM(drv_SM), .drv_step(drv_step), .drv_dir(drv_dir),
        .locked(locked), .fault(fault), .avg(avg)
    );

    always #5 clk = ~clk;

    typedef enum int {M_IDLE, M_ACQ, M_HOLD, M_SLOW, M_FAST, M_FAULT} mode_t;

    mode_t mode = M_IDLE;
    mode_t pz   = M_HOLD;
    int    q[$];
    int    m_avg = 0;
    int    t0    = 0;
    int    steps = 0;
    int    cyc   = 0;
    bit    ok_due = 0;
    bit    pend   = 0;
    bit    pd     = 0;
    bit    mdir   = 0;
    bit    mv     = 0;

    function automatic int period(input mode_t m);
        return (m == M_FAST) ? DIV_F : DIV_S;
    endfunction

    function automatic mode_t zone_of(input int a);
        int mag;
        mag = (a > int'(x0)) ? a - int'(x0) : int'(x0) - a;
        if (mag <= int'(dx1)) return M_HOLD;
        if (mag > int'(dx2)) return M_FAST;
        return M_SLOW;
    endfunction

    always @(posedge clk) begin
        bit dec;
        int a;
        int ph;
        int s;
        cyc++;
        mv = rst;
        if (!rst) begin
            mode = M_IDLE; q.delete(); m_avg = 0; ok_due = 0;
            steps = 0; pend = 0; mdir = 0; t0 = 0;
        end else begin
            dec = ok_due;
            a = m_avg;
            ok_due = 0;
            if (!en) begin
                q.delete();
            end else if (adc.data_valid) begin
                q.push_back(int'(adc.x));
                if (q.size() == NAVG) begin
                    s = 0;
                    foreach (q[i]) s += q[i];
                    m_avg = s / NAVG;
                    q.delete();
                    ok_due = 1;
                end
            end
            if (!en) begin
                mode = M_IDLE; steps = 0; pend = 0;
            end else begin
                case (mode)
                    M_IDLE: mode = M_ACQ;
                    M_ACQ, M_HOLD: begin
                        steps = 0;
                        if (dec) begin
                            mdir = a > int'(x0);
                            mode = zone_of(a);
                            t0 = cyc + 1;
                        end
                    end
                    M_SLOW, M_FAST: begin
                        ph = (cyc - t0) % period(mode);
                        if (dec) begin
                            pend = 1; pz = zone_of(a); pd = a > int'(x0);
                        end
                        if (ph == period(mode) - 1) begin
                            if (steps >= MAXS) begin
                                mode = M_FAULT;
                            end else if (pend) begin
                                mode = pz; mdir = pd; t0 = cyc + 1;
                            end
                            pend = 0;
                        end else if (ph == 0) begin
                            steps++;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        bit e_sm, e_st, e_lk, e_ft;
        if (mv && rst) begin
            e_sm = mode inside {M_ACQ, M_HOLD, M_SLOW, M_FAST};
            e_st = (mode == M_SLOW || mode == M_FAST) && cyc >= t0
                   && ((cyc - t0) % period(mode)) < PWID;
            e_lk = mode == M_HOLD;
            e_ft = mode == M_FAULT;
            total++;
            if (drv_SM !== e_sm || drv_step !== e_st || drv_dir !== mdir
                || locked !== e_lk || fault !== e_ft || int'(avg) != m_avg) begin
                bad++;
                $display("FAIL model cyc=%0d sm/step/dir/lk/flt/avg got %b%b%b%b%b/%0d want %b%b%b%b%b/%0d",
                         cyc, drv_SM, drv_step, drv_dir, locked, fault, avg,
                         e_sm, e_st, mdir, e_lk, e_ft, m_avg);
            end
        end
    end

    int tcyc  = 0;
    int highs = 0;
    int tf;
    int smlow;
    bit pstep = 0;
    int rise_t[$];

    task automatic tick();
        @(posedge clk);
        #2;
        tcyc++;
        if (drv_step && !pstep) rise_t.push_back(tcyc);
        if (drv_step) highs++;
        pstep = drv_step;
    endtask

    function automatic int rt(input int i);
        return (i < rise_t.size()) ? rise_t[i] : -100;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic feed(input int v, input int n);
        for (int i = 0; i < n; i++) begin
            adc.x = 12'(v);
            adc.data_valid = 1'b1;
            tick();
            adc.data_valid = 1'b0;
            repeat (4) tick();
        end
    endtask

    task automatic wait_pulse(input string nm);
        int k;
        k = 0;
        while (!drv_step && k < 20) begin
            tick();
            k++;
        end
        chk(nm, int'(drv_step), 1);
    endtask

    initial begin
        rst = 1'b0; en = 1'b0;
        adc.data_valid = 1'b0; adc.x = '0;
        x0 = 12'd5; dx1 = 12'd5; dx2 = 12'd10;
        repeat (3) tick();
        chk("rst_sm", int'(drv_SM), 0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_avg", int'(avg), 0);
        rst = 1'b1; en = 1'b1;

        // reset while stepping in FAST
        feed(25, 4);
        wait_pulse("t1_fast_pulse");
        #1 rst = 1'b0;
        #1;
        chk("t1_async_step", int'(drv_step), 0);
        chk("t1_async_sm", int'(drv_SM), 0);
        chk("t1_async_dir", int'(drv_dir), 0);
        chk("t1_async_avg", int'(avg), 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t1_acq_sm", int'(drv_SM), 1);

        // HOLD inside deadband
        rise_t.delete();
        feed(8, 4);
        chk("t2_acq_nostep", rise_t.size(), 0);
        chk("t2_avg", int'(avg), 8);
        chk("t2_locked", int'(locked), 1);
        smlow = 0;
        repeat (100) begin
            tick();
            if (!drv_SM) smlow++;
        end
        chk("t2_hold_nostep", rise_t.size(), 0);
        chk("t2_hold_sm", smlow, 0);

        // FAST, re-zone to SLOW, step limit
        rise_t.delete(); highs = 0;
        feed(25, 4);
        chk("t3_avg", int'(avg), 25);
        chk("t3_dir", int'(drv_dir), 1);
        feed(12, 4);
        tf = -1;
        for (int i = 0; i < 30 && tf < 0; i++) begin
            tick();
            if (fault) tf = tcyc;
        end
        chk("t5_fault", int'(fault), 1);
        chk("t5_fault_sm", int'(drv_SM), 0);
        chk("t3_rises", rise_t.size(), 6);
        chk("t3_width", highs, 6);
        chk("t3_fast_period", rt(1) - rt(0), 4);
        chk("t3_slow_first", rt(5) - rt(4), 4);
        chk("t5_slow_bnd", tf - rt(5), 7);
        en = 1'b0;
        tick();
        chk("t5_clear_fault", int'(fault), 0);
        chk("t5_idle_sm", int'(drv_SM), 0);
        en = 1'b1;
        tick();
        chk("t5_reacq_sm", int'(drv_SM), 1);

        // FAST into HOLD at a boundary, then SLOW
        rise_t.delete(); highs = 0;
        feed(25, 4);
        feed(0, 4);
        chk("t4_locked", int'(locked), 1);
        chk("t4_dir_down", int'(drv_dir), 0);
        chk("t4_rises", rise_t.size(), 5);
        chk("t4_width", highs, 5);
        rise_t.delete();
        feed(15, 4);
        repeat (10) tick();
        chk("t4_slow_unlock", int'(locked), 0);
        chk("t4_slow_dir", int'(drv_dir), 1);
        chk("t4_slow_rises", rise_t.size(), 2);
        chk("t4_slow_period", rt(1) - rt(0), 8);

        // enable dropped mid-pulse, accumulator restart
        wait_pulse("t6_pulse");
        en = 1'b0;
        tick();
        chk("t6_cut_step", int'(drv_step), 0);
        chk("t6_cut_sm", int'(drv_SM), 0);
        en = 1'b1;
        tick();
        feed(100, 3);
        adc.data_valid = 1'b1; adc.x = 12'd100; en = 1'b0;
        tick();
        adc.data_valid = 1'b0;
        tick();
        en = 1'b1;
        tick();
        feed(20, 4);
        chk("t6_avg_last4", int'(avg), 20);
        repeat (10) tick();
        chk("t6_fast_dir", int'(drv_dir), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL watchdog: got no end want end");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
